// File: rtl/cycle_sequencer.sv
// Multi-cycle phase controller: one clock, per-stage enable strobes for FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Optional macro SINGLE_STEP_EN adds step_mode, forcing WB -> IDLE so each run pulse retires one instruction.
module cycle_sequencer #(
   parameter int MUU_LATENCY = 4,
   parameter int MEM_WAIT    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        halt_req,
`ifdef SINGLE_STEP_EN
   input  logic        step_mode,
`endif
   input  logic        muu_op,
   input  logic        mem_access,
   input  logic        exception,
   output logic        pc_en,
   output logic        inst_en,
   output logic        reg_en,
   output logic        data_en,
   output logic        muu_en,
   output logic        epc_we,
   output logic        trap,
   output logic        busy,
   output logic [2:0]  state,
   output logic [31:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   // Counters hold "cycles remaining after this one"; a zero parameter behaves as one cycle.
   localparam logic [7:0] EXEC_MUU_LAST = (MUU_LATENCY <= 1) ? 8'd0 : 8'(MUU_LATENCY - 1);
   localparam logic [7:0] MEM_FIRST     = (MEM_WAIT <= 1)    ? 8'd0 : 8'(MEM_WAIT - 1);

   state_t      cur, nxt;
   logic [7:0]  wait_cnt;
   logic        muu_lat;
   logic        step;

`ifdef SINGLE_STEP_EN
   assign step = step_mode;
`else
   assign step = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) cur <= S_IDLE;
      else       cur <= nxt;
   end

   always_comb begin
      nxt     = cur;
      pc_en   = 1'b0;
      inst_en = 1'b0;
      reg_en  = 1'b0;
      data_en = 1'b0;
      muu_en  = 1'b0;
      epc_we  = 1'b0;
      case (cur)
         S_IDLE: begin
            if (run) nxt = S_FETCH;
         end
         S_FETCH: begin
            inst_en = 1'b1;
            nxt     = S_DECODE;
         end
         S_DECODE: begin
            nxt = S_EXEC;
         end
         S_EXEC: begin
            muu_en = muu_lat;
            if (wait_cnt == 8'd0) begin
               if (exception)       nxt = S_TRAP;
               else if (mem_access) nxt = S_MEM;
               else                 nxt = S_WB;
            end
         end
         S_MEM: begin
            data_en = (wait_cnt == MEM_FIRST);
            if (wait_cnt == 8'd0) nxt = S_WB;
         end
         S_WB: begin
            reg_en = 1'b1;
            pc_en  = 1'b1;
            if (halt_req || !run || step) nxt = S_IDLE;
            else                          nxt = S_FETCH;
         end
         S_TRAP: begin
            epc_we = 1'b1;
            pc_en  = 1'b1;
            nxt    = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // muu_op is captured on the edge that opens EXEC so muu_en stays a registered-state decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt    <= 8'd0;
         muu_lat     <= 1'b0;
         trap        <= 1'b0;
         instr_count <= 32'd0;
      end else begin
         case (cur)
            S_IDLE: begin
               if (run) trap <= 1'b0;
            end
            S_DECODE: begin
               muu_lat  <= muu_op;
               wait_cnt <= muu_op ? EXEC_MUU_LAST : 8'd0;
            end
            S_EXEC: begin
               if (wait_cnt != 8'd0)               wait_cnt <= wait_cnt - 8'd1;
               else if (!exception && mem_access)  wait_cnt <= MEM_FIRST;
            end
            S_MEM: begin
               if (wait_cnt != 8'd0) wait_cnt <= wait_cnt - 8'd1;
            end
            S_WB: begin
               instr_count <= instr_count + 32'd1;
            end
            S_TRAP: begin
               trap <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy  = (cur != S_IDLE);
   assign state = cur;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer (MUU_LATENCY=4, MEM_WAIT=3); step-mode scenario when SINGLE_STEP_EN is defined.
module tb_cycle_sequencer;

   logic        clk = 1'b0;
   logic        reset, run, halt_req, muu_op, mem_access, exception;
   logic        step_mode;
   logic        pc_en, inst_en, reg_en, data_en, muu_en, epc_we, trap, busy;
   logic [2:0]  state;
   logic [31:0] instr_count;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   cycle_sequencer #(.MUU_LATENCY(4), .MEM_WAIT(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .halt_req   (halt_req),
`ifdef SINGLE_STEP_EN
      .step_mode  (step_mode),
`endif
      .muu_op     (muu_op),
      .mem_access (mem_access),
      .exception  (exception),
      .pc_en      (pc_en),
      .inst_en    (inst_en),
      .reg_en     (reg_en),
      .data_en    (data_en),
      .muu_en     (muu_en),
      .epc_we     (epc_we),
      .trap       (trap),
      .busy       (busy),
      .state      (state),
      .instr_count(instr_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; run = 1'b0; halt_req = 1'b0; muu_op = 1'b0;
      mem_access = 1'b0; exception = 1'b0; step_mode = 1'b0;
      tick(); tick();
      reset = 1'b0;
      n_cmp++;
      if ({state, pc_en, inst_en, reg_en, data_en, muu_en, epc_we, trap, busy} !== 11'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got state=%0d strobes=%b want all 0", state,
                  {pc_en, inst_en, reg_en, data_en, muu_en, epc_we, trap, busy});
      end
      n_cmp++;
      if (instr_count !== 32'd0) begin
         n_err++; $display("FAIL reset_count: got %0d want 0", instr_count);
      end
   endtask

   task automatic test_plain();
      logic [2:0] exp_st [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
      logic [1:0] exp_ir [4] = '{2'b10, 2'b00, 2'b00, 2'b01};
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (state !== exp_st[i] || {inst_en, reg_en} !== exp_ir[i] || pc_en !== exp_ir[i][0]) begin
            n_err++;
            $display("FAIL plain_cyc%0d: got state=%0d inst/reg/pc=%b%b%b want state=%0d inst/reg=%b",
                     i + 1, state, inst_en, reg_en, pc_en, exp_st[i], exp_ir[i]);
         end
      end
      tick();
      n_cmp++;
      if (state !== 3'd1 || instr_count !== 32'd1) begin
         n_err++; $display("FAIL plain_retire: got state=%0d count=%0d want 1/1", state, instr_count);
      end
      for (int i = 0; i < 36; i++) begin
         tick();
         n_cmp++;
         if ($countones({inst_en, data_en, reg_en, epc_we}) > 1) begin
            n_err++; $display("FAIL strobe_exclusive: got %b want at most one", {inst_en, data_en, reg_en, epc_we});
         end
      end
      n_cmp++;
      if (state !== 3'd1 || instr_count !== 32'd10) begin
         n_err++; $display("FAIL plain_40cyc: got state=%0d count=%0d want 1/10", state, instr_count);
      end
      run = 1'b0;
      tick(); tick(); tick(); tick();
      n_cmp++;
      if (state !== 3'd0 || busy !== 1'b0 || instr_count !== 32'd11) begin
         n_err++; $display("FAIL run_drop_completes: got state=%0d busy=%b count=%0d want 0/0/11",
                           state, busy, instr_count);
      end
   endtask

   task automatic test_load();
      logic [2:0] exp_st [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};
      logic       exp_de [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      run = 1'b1; mem_access = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         run = 1'b0;
         n_cmp++;
         if (state !== exp_st[i] || data_en !== exp_de[i]) begin
            n_err++; $display("FAIL load_cyc%0d: got state=%0d data_en=%b want %0d/%b",
                              i + 1, state, data_en, exp_st[i], exp_de[i]);
         end
      end
      mem_access = 1'b0;
      n_cmp++;
      if (instr_count !== 32'd12) begin
         n_err++; $display("FAIL load_count: got %0d want 12", instr_count);
      end
   endtask

   task automatic test_muu();
      logic [2:0] exp_st [8] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5, 3'd0};
      logic       exp_mu [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       exp_re [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      run = 1'b1; muu_op = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         run = 1'b0;
         if (i == 3) muu_op = 1'b0;
         if (i == 4) muu_op = 1'b1;
         n_cmp++;
         if (state !== exp_st[i] || muu_en !== exp_mu[i] || reg_en !== exp_re[i]) begin
            n_err++; $display("FAIL muu_cyc%0d: got state=%0d muu_en=%b reg_en=%b want %0d/%b/%b",
                              i + 1, state, muu_en, reg_en, exp_st[i], exp_mu[i], exp_re[i]);
         end
      end
      muu_op = 1'b0;
      n_cmp++;
      if (instr_count !== 32'd13) begin
         n_err++; $display("FAIL muu_count: got %0d want 13", instr_count);
      end
   endtask

   task automatic test_exception();
      run = 1'b1; mem_access = 1'b1; exception = 1'b1;
      tick(); run = 1'b0;
      tick(); tick();
      tick();
      n_cmp++;
      if (state !== 3'd6 || {epc_we, pc_en, data_en, reg_en} !== 4'b1100) begin
         n_err++; $display("FAIL trap_strobes: got state=%0d epc/pc/data/reg=%b want 6/1100",
                           state, {epc_we, pc_en, data_en, reg_en});
      end
      tick();
      mem_access = 1'b0; exception = 1'b0;
      n_cmp++;
      if (state !== 3'd0 || trap !== 1'b1 || instr_count !== 32'd13) begin
         n_err++; $display("FAIL trap_sticky: got state=%0d trap=%b count=%0d want 0/1/13",
                           state, trap, instr_count);
      end
      tick();
      n_cmp++;
      if (trap !== 1'b1) begin
         n_err++; $display("FAIL trap_hold_idle: got %b want 1", trap);
      end
      run = 1'b1;
      tick();
      run = 1'b0;
      n_cmp++;
      if (state !== 3'd1 || trap !== 1'b0) begin
         n_err++; $display("FAIL trap_clear: got state=%0d trap=%b want 1/0", state, trap);
      end
      tick(); tick(); tick(); tick();
      n_cmp++;
      if (state !== 3'd0 || instr_count !== 32'd14) begin
         n_err++; $display("FAIL trap_resume: got state=%0d count=%0d want 0/14", state, instr_count);
      end
   endtask

   task automatic test_halt();
      run = 1'b1;
      tick(); tick(); tick();
      halt_req = 1'b1;
      tick();
      n_cmp++;
      if (state !== 3'd5) begin
         n_err++; $display("FAIL halt_wb: got state=%0d want 5", state);
      end
      tick();
      n_cmp++;
      if (state !== 3'd0 || busy !== 1'b0 || instr_count !== 32'd15) begin
         n_err++; $display("FAIL halt_idle: got state=%0d busy=%b count=%0d want 0/0/15",
                           state, busy, instr_count);
      end
      halt_req = 1'b0; run = 1'b0;
   endtask

   task automatic test_reset_mid();
      run = 1'b1; mem_access = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      n_cmp++;
      if (state !== 3'd4) begin
         n_err++; $display("FAIL mid_mem_reach: got state=%0d want 4", state);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0; run = 1'b0; mem_access = 1'b0;
      n_cmp++;
      if (state !== 3'd0 || {pc_en, inst_en, reg_en, data_en, muu_en, epc_we, busy} !== 7'd0
          || instr_count !== 32'd0) begin
         n_err++; $display("FAIL mid_reset: got state=%0d strobes=%b count=%0d want 0/0/0", state,
                           {pc_en, inst_en, reg_en, data_en, muu_en, epc_we, busy}, instr_count);
      end
   endtask

`ifdef SINGLE_STEP_EN
   task automatic test_step();
      step_mode = 1'b1; run = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      n_cmp++;
      if (instr_count !== 32'd4 || state !== 3'd0) begin
         n_err++; $display("FAIL step_mode: got count=%0d state=%0d want 4/0", instr_count, state);
      end
      run = 1'b0; step_mode = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_plain();
      test_load();
      test_muu();
      test_exception();
      test_halt();
      test_reset_mid();
`ifdef SINGLE_STEP_EN
      test_step();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
